microctrl: RTL and testbench
============================

MICROCTRL -- requirements
Module: microctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset of the micro-program counter (uPC).
REQ-004 opcode  input  6  instruction opcode (IR[31:26]), sampled combinationally at dispatch.
REQ-005 out  output  18  current microinstruction control word.
REQ-006 out bit map SHALL be, MSB first:
- [17] PCWrite, [16] PCWriteCond, [15] IorD, [14] MemRead, [13] MemWrite
- [12] IRWrite, [11] MemtoReg, [10:9] PCSource, [8:7] ALUOp
- [6:5] ALUSrcB, [4] ALUSrcA, [3] RegWrite, [2] RegDst, [1:0] AddrCtl

Function
REQ-007 The block SHALL be a microprogrammed multicycle MIPS controller: a 4-bit uPC, a 16-entry x 18-bit micro-ROM and a next-address sequencer.
REQ-008 out SHALL be a combinational ROM read of the current uPC, with no output register.
REQ-009 ROM contents (hex) SHALL be:
- 0 0x25023 fetch
- 1 0x00061 decode
- 2 0x00052 mem-addr
- 3 0x0C003 lw-read
- 4 0x00808 lw-writeback
- 5 0x0A000 sw
- 6 0x00113 R-execute
- 7 0x0000C R-writeback
- 8 0x10290 beq
- 9 0x20400 jump
- 10-15 0x00000
REQ-010 On each rising clk edge with rst=0, uPC SHALL load the next address selected by AddrCtl=out[1:0]:
- 00 -> 0
- 01 -> dispatch-1(opcode)
- 10 -> dispatch-2(opcode)
- 11 -> uPC+1
REQ-011 dispatch-1 SHALL map:
- 000000 -> 6
- 000010 -> 9
- 000100 -> 8
- 100011 -> 2
- 101011 -> 2
- any other opcode -> 0 (illegal opcode returns to fetch)
REQ-012 dispatch-2 SHALL map 100011 -> 3, 101011 -> 5, and any other opcode -> 0.
REQ-013 Unused addresses 10-15 carry AddrCtl=00 and SHALL return to 0 on the next edge.
REQ-014 Opcode changes SHALL affect sequencing only in cycles whose AddrCtl is 01 or 10.
REQ-015 Instruction lengths in cycles (including fetch) SHALL be:
- j 3
- beq 3
- R-type 4
- sw 4
- lw 5

Reset
REQ-016 When rst=1 at a rising edge, uPC SHALL become 0, overriding AddrCtl and opcode.
REQ-017 out SHALL equal 0x25023 in the cycle after reset is sampled.
REQ-018 Reset asserted mid-instruction SHALL abort the instruction and restart at fetch.
REQ-019 Deasserting reset SHALL resume normal sequencing from address 0 at the next edge.
REQ-020 After power-up and before the first reset, uPC SHALL initialise to 0.

Verification
REQ-021 rst=1 for one edge, then opcode=000010 held for 9 edges -> out cycles 0x25023, 0x00061, 0x20400 and repeats three times.
REQ-022 opcode=100011 (lw) from fetch -> 0x25023, 0x00061, 0x00052, 0x0C003, 0x00808, then 0x25023.
REQ-023 opcode=101011 (sw) -> 0x25023, 0x00061, 0x00052, 0x0A000, 0x25023; opcode=000000 -> 0x25023, 0x00061, 0x00113, 0x0000C, 0x25023.
REQ-024 opcode=000100 (beq) -> 0x25023, 0x00061, 0x10290, 0x25023; opcode=111111 -> 0x25023, 0x00061, 0x25023.
REQ-025 lw in progress at uPC=3 with rst=1 for one edge -> out=0x25023 next cycle, then normal fetch/decode.
REQ-026 Opcode toggled in fetch and lw-read cycles -> path depends only on the opcode at decode and mem-addr.

Source files
------------

// File: rtl/microctrl.sv
// Microprogrammed multicycle MIPS controller.
// A 4-bit micro-PC addresses a 16 x 18-bit micro-ROM; the low two bits of each
// microword (AddrCtl) pick the next micro-address: fetch, dispatch-1,
// dispatch-2 or sequential increment. The control word is an unregistered ROM read.
module microctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    output logic [17:0] out
);

    // AddrCtl encodings carried in out[1:0]
    localparam logic [1:0] ADDR_FETCH = 2'b00;
    localparam logic [1:0] ADDR_DISP1 = 2'b01;
    localparam logic [1:0] ADDR_DISP2 = 2'b10;
    localparam logic [1:0] ADDR_SEQ   = 2'b11;

    // Opcodes understood by the dispatch tables
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Microprogram contents; addresses 10-15 are zero so they fall back to fetch
    function automatic logic [17:0] rom_word(input int addr);
        logic [17:0] word;
        case (addr)
            0:       word = 18'h25023; // fetch
            1:       word = 18'h00061; // decode
            2:       word = 18'h00052; // mem-addr
            3:       word = 18'h0C003; // lw-read
            4:       word = 18'h00808; // lw-writeback
            5:       word = 18'h0A000; // sw
            6:       word = 18'h00113; // R-execute
            7:       word = 18'h0000C; // R-writeback
            8:       word = 18'h10290; // beq
            9:       word = 18'h20400; // jump
            default: word = 18'h00000;
        endcase
        return word;
    endfunction

    logic [17:0] rom [16];
    logic [3:0]  upc_reg = 4'd0;   // power-up value before any reset
    logic [3:0]  upc_next;
    logic [3:0]  disp1;
    logic [3:0]  disp2;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rom
            assign rom[gi] = rom_word(gi);
        end
    endgenerate

    // Control word is the ROM entry at the current micro-address
    assign out = rom[upc_reg];

    // Dispatch tables: decode-stage and memory-address-stage branch targets
    always_comb begin
        disp1 = 4'd0;
        disp2 = 4'd0;
        case (opcode)
            OP_RTYPE: disp1 = 4'd6;
            OP_J:     disp1 = 4'd9;
            OP_BEQ:   disp1 = 4'd8;
            OP_LW:    disp1 = 4'd2;
            OP_SW:    disp1 = 4'd2;
            default:  disp1 = 4'd0;
        endcase
        case (opcode)
            OP_LW:   disp2 = 4'd3;
            OP_SW:   disp2 = 4'd5;
            default: disp2 = 4'd0;
        endcase
    end

    // Next-address selection; opcode only matters on dispatch cycles
    always_comb begin
        upc_next = 4'd0;
        case (out[1:0])
            ADDR_FETCH: upc_next = 4'd0;
            ADDR_DISP1: upc_next = disp1;
            ADDR_DISP2: upc_next = disp2;
            ADDR_SEQ:   upc_next = upc_reg + 4'd1;
            default:    upc_next = 4'd0;
        endcase
    end

    // Micro-PC register; reset forces a restart at fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            upc_reg <= 4'd0;
        end else begin
            upc_reg <= upc_next;
        end
    end

endmodule

// File: tb/tb_microctrl.sv
// Directed bench for microctrl: walks each instruction class through the
// microprogram and compares the control word every cycle.
module tb_microctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [17:0] out;

    int errors = 0;
    int checks = 0;

    localparam logic [17:0] W_FETCH = 18'h25023;
    localparam logic [17:0] W_DEC   = 18'h00061;
    localparam logic [17:0] W_MADDR = 18'h00052;
    localparam logic [17:0] W_LWRD  = 18'h0C003;
    localparam logic [17:0] W_LWWB  = 18'h00808;
    localparam logic [17:0] W_SW    = 18'h0A000;
    localparam logic [17:0] W_REX   = 18'h00113;
    localparam logic [17:0] W_RWB   = 18'h0000C;
    localparam logic [17:0] W_BEQ   = 18'h10290;
    localparam logic [17:0] W_J     = 18'h20400;

    microctrl dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup();
        checks++;
        if (out !== W_FETCH) begin
            errors++;
            $display("FAIL powerup: out=%05h expected=%05h", out, W_FETCH);
        end
        $display("powerup: out=%05h", out);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out !== W_FETCH) begin
                errors++;
                $display("FAIL reset_hold[%0d]: out=%05h expected=%05h", i, out, W_FETCH);
            end
            $display("reset edge %0d: out=%05h", i, out);
        end
        rst = 1'b0;
    endtask

    task automatic test_jump();
        logic [17:0] exp_w [3];
        exp_w = '{W_FETCH, W_DEC, W_J};
        opcode = 6'b000010;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out !== exp_w[i % 3]) begin
                errors++;
                $display("FAIL jump[%0d]: out=%05h expected=%05h", i, out, exp_w[i % 3]);
            end
            $display("jump cycle %0d: out=%05h", i, out);
            if (i < 9) tick();
        end
    endtask

    task automatic test_lw();
        logic [17:0] exp_w [6];
        exp_w = '{W_FETCH, W_DEC, W_MADDR, W_LWRD, W_LWWB, W_FETCH};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out !== exp_w[i]) begin
                errors++;
                $display("FAIL lw[%0d]: out=%05h expected=%05h", i, out, exp_w[i]);
            end
            $display("lw cycle %0d: out=%05h", i, out);
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        logic [17:0] exp_w [5];
        exp_w = '{W_FETCH, W_DEC, W_MADDR, W_SW, W_FETCH};
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out !== exp_w[i]) begin
                errors++;
                $display("FAIL sw[%0d]: out=%05h expected=%05h", i, out, exp_w[i]);
            end
            $display("sw cycle %0d: out=%05h", i, out);
            if (i < 4) tick();
        end
    endtask

    task automatic test_rtype();
        logic [17:0] exp_w [5];
        exp_w = '{W_FETCH, W_DEC, W_REX, W_RWB, W_FETCH};
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out !== exp_w[i]) begin
                errors++;
                $display("FAIL rtype[%0d]: out=%05h expected=%05h", i, out, exp_w[i]);
            end
            $display("rtype cycle %0d: out=%05h", i, out);
            if (i < 4) tick();
        end
    endtask

    task automatic test_beq();
        logic [17:0] exp_w [4];
        exp_w = '{W_FETCH, W_DEC, W_BEQ, W_FETCH};
        opcode = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out !== exp_w[i]) begin
                errors++;
                $display("FAIL beq[%0d]: out=%05h expected=%05h", i, out, exp_w[i]);
            end
            $display("beq cycle %0d: out=%05h", i, out);
            if (i < 3) tick();
        end
    endtask

    task automatic test_illegal();
        logic [17:0] exp_w [3];
        exp_w = '{W_FETCH, W_DEC, W_FETCH};
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out !== exp_w[i]) begin
                errors++;
                $display("FAIL illegal[%0d]: out=%05h expected=%05h", i, out, exp_w[i]);
            end
            $display("illegal cycle %0d: out=%05h", i, out);
            if (i < 2) tick();
        end
    endtask

    // Reset while lw sits in lw-read, then resume a normal lw
    task automatic test_reset_mid();
        logic [17:0] exp_w [5];
        exp_w = '{W_DEC, W_MADDR, W_LWRD, W_LWWB, W_FETCH};
        opcode = 6'b100011;
        tick(); tick(); tick();
        checks++;
        if (out !== W_LWRD) begin
            errors++;
            $display("FAIL mid_pre: out=%05h expected=%05h", out, W_LWRD);
        end
        $display("mid reset before: out=%05h", out);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out !== W_FETCH) begin
            errors++;
            $display("FAIL mid_reset: out=%05h expected=%05h", out, W_FETCH);
        end
        $display("mid reset after: out=%05h", out);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out !== exp_w[i]) begin
                errors++;
                $display("FAIL mid_resume[%0d]: out=%05h expected=%05h", i, out, exp_w[i]);
            end
            $display("mid resume %0d: out=%05h", i, out);
        end
    endtask

    // Opcode changes outside dispatch cycles must not steer the sequence
    task automatic test_opcode_toggle();
        // fetch sees R-type, decode sees lw, lw-read sees beq
        opcode = 6'b000000;
        tick();
        opcode = 6'b100011;
        tick();
        checks++;
        if (out !== W_MADDR) begin
            errors++;
            $display("FAIL toggle_decode: out=%05h expected=%05h", out, W_MADDR);
        end
        $display("toggle a1: out=%05h", out);
        tick();
        checks++;
        if (out !== W_LWRD) begin
            errors++;
            $display("FAIL toggle_maddr: out=%05h expected=%05h", out, W_LWRD);
        end
        $display("toggle a2: out=%05h", out);
        opcode = 6'b000100;
        tick();
        checks++;
        if (out !== W_LWWB) begin
            errors++;
            $display("FAIL toggle_lwread: out=%05h expected=%05h", out, W_LWWB);
        end
        $display("toggle a3: out=%05h", out);
        tick();
        checks++;
        if (out !== W_FETCH) begin
            errors++;
            $display("FAIL toggle_end: out=%05h expected=%05h", out, W_FETCH);
        end
        $display("toggle a4: out=%05h", out);

        // decode sees sw, mem-addr sees lw: second dispatch follows lw
        opcode = 6'b101011;
        tick(); tick();
        opcode = 6'b100011;
        tick();
        checks++;
        if (out !== W_LWRD) begin
            errors++;
            $display("FAIL toggle_disp2_lw: out=%05h expected=%05h", out, W_LWRD);
        end
        $display("toggle b: out=%05h", out);
        tick(); tick();

        // decode sees lw, mem-addr sees R-type: second dispatch falls back to fetch
        opcode = 6'b100011;
        tick(); tick();
        opcode = 6'b000000;
        tick();
        checks++;
        if (out !== W_FETCH) begin
            errors++;
            $display("FAIL toggle_disp2_other: out=%05h expected=%05h", out, W_FETCH);
        end
        $display("toggle c: out=%05h", out);
    endtask

    // beq immediately followed by j, counting cycles to each fetch
    task automatic test_back_to_back();
        logic [17:0] exp_w [6];
        logic [5:0]  ops [6];
        exp_w = '{W_DEC, W_BEQ, W_FETCH, W_DEC, W_J, W_FETCH};
        ops   = '{6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010, 6'b000010};
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            tick();
            checks++;
            if (out !== exp_w[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: out=%05h expected=%05h", i, out, exp_w[i]);
            end
            $display("b2b cycle %0d: out=%05h", i, out);
        end
    endtask

    initial begin
        rst    = 1'b0;
        opcode = 6'b000000;
        #1;
        test_powerup();
        test_reset();
        test_jump();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_illegal();
        test_reset_mid();
        test_opcode_toggle();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
